// File: rtl/reg_file_mp.sv
// Multi-port register file: one synchronous write port, NREAD registered read ports
// with optional write bypass, optional hardwired zero register and a clear sequencer.
module reg_file_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic [NREAD-1:0]       rd_en,
    input  logic [NREAD*AW-1:0]    rd_addr,
    output logic [NREAD*WIDTH-1:0] rd_data,
    output logic [NREAD-1:0]       rd_valid,
    input  logic                   clr_req,
    output logic                   clr_busy,
    output logic                   clr_done
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } clrState_t;

    // One extra bit so the range check also works when DEPTH is a power of two.
    localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

    logic [WIDTH-1:0] regs [DEPTH];
    clrState_t        state;
    clrState_t        stateNext;
    logic [AW-1:0]    clrCount;
    logic             wrValid;

    assign wrValid = we && (state != CLEAR) && ({1'b0, wr_addr} < DEPTH_EXT)
                     && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            clrCount <= '0;
        end else begin
            state <= stateNext;
            if (state == CLEAR) begin
                clrCount <= clrCount + 1'b1;
            end else begin
                clrCount <= '0;
            end
        end
    end

    always_comb begin
        stateNext = state;
        clr_busy  = 1'b0;
        clr_done  = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    stateNext = CLEAR;
                end
            end
            CLEAR: begin
                clr_busy = 1'b1;
                if (clrCount == LAST_IDX) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                clr_busy  = 1'b1;
                clr_done  = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // The clear sweep owns the storage while it runs; user writes are simply dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[clrCount] <= '0;
        end else if (wrValid) begin
            regs[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_read
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] value;
        logic [WIDTH-1:0] dataQ;
        logic             validQ;

        assign addr = rd_addr[p*AW +: AW];

        always_comb begin
            value = '0;
            if ({1'b0, addr} >= DEPTH_EXT) begin
                value = '0;
            end else if ((ZERO_REG != 0) && (addr == '0)) begin
                value = '0;
            end else if (state == DONE) begin
                value = '0;
            end else if ((BYPASS != 0) && wrValid && (wr_addr == addr)) begin
                value = wr_data;
            end else begin
                value = regs[addr];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dataQ  <= '0;
                validQ <= 1'b0;
            end else begin
                validQ <= rd_en[p];
                if (rd_en[p]) begin
                    dataQ <= value;
                end
            end
        end

        assign rd_data[p*WIDTH +: WIDTH] = dataQ;
        assign rd_valid[p]               = validQ;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a default instance plus no-bypass and DEPTH=20
// variants driven by the same stimulus.
module tb_reg_file_mp;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic            clk     = 1'b0;
    logic            rst_n   = 1'b0;
    logic            we      = 1'b0;
    logic            clr_req = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [W-1:0]    wr_data = '0;
    logic [NR-1:0]   rd_en   = '0;
    logic [NR*AW-1:0] rd_addr = '0;

    logic [NR*W-1:0] dataM, dataN, dataS;
    logic [NR-1:0]   validM, validN, validS;
    logic            busyM, doneM, busyN, doneN, busyS, doneS;

    int compared   = 0;
    int mismatched = 0;
    int cnt;
    logic sawDone;

    always #5 clk = ~clk;

    reg_file_mp dutMain (
        .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(dataM), .rd_valid(validM),
        .clr_req(clr_req), .clr_busy(busyM), .clr_done(doneM)
    );

    reg_file_mp #(.BYPASS(0)) dutNoBypass (
        .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(dataN), .rd_valid(validN),
        .clr_req(clr_req), .clr_busy(busyN), .clr_done(doneN)
    );

    reg_file_mp #(.DEPTH(20)) dutSmall (
        .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(dataS), .rd_valid(validS),
        .clr_req(clr_req), .clr_busy(busyS), .clr_done(doneS)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs, then move to just after the capturing edge.
    task automatic applyStimulus(input logic wEn, input logic [4:0] wA, input logic [31:0] wD,
                                 input logic [1:0] rEn, input logic [4:0] a0,
                                 input logic [4:0] a1);
        we      = wEn;
        wr_addr = wA;
        wr_data = wD;
        rd_en   = rEn;
        rd_addr = {a1, a0};
        stepClock();
    endtask

    initial begin
        stepClock();
        stepClock();
        checkOutput("rst_data", dataM[31:0], 32'h0);
        checkOutput("rst_valid", 32'(validM), 32'h0);
        checkOutput("rst_busy", 32'(busyM), 32'h0);
        checkOutput("rst_done", 32'(doneM), 32'h0);
        rst_n = 1'b1;
        stepClock();

        // Async reset wipes read data, valid and storage.
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 2'b00, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 2'b01, 5'd5, 5'd0);
        checkOutput("r5_before_rst", dataM[31:0], 32'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        checkOutput("async_data", dataM[31:0], 32'h0);
        checkOutput("async_valid", 32'(validM), 32'h0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 2'b01, 5'd5, 5'd0);
        checkOutput("r5_after_rst", dataM[31:0], 32'h0);
        checkOutput("r5_after_rst_valid", 32'(validM[0]), 32'h1);

        // Write then read, then hold with rd_en low.
        applyStimulus(1'b1, 5'd7, 32'h12345678, 2'b00, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd0);
        checkOutput("r7_read", dataM[31:0], 32'h12345678);
        checkOutput("r7_valid", 32'(validM[0]), 32'h1);
        applyStimulus(1'b0, 5'd0, 32'h0, 2'b00, 5'd7, 5'd0);
        checkOutput("r7_hold", dataM[31:0], 32'h12345678);
        checkOutput("r7_hold_valid", 32'(validM[0]), 32'h0);

        // Same-cycle write and dual read of r3.
        applyStimulus(1'b1, 5'd3, 32'h1, 2'b00, 5'd0, 5'd0);
        applyStimulus(1'b1, 5'd3, 32'hAAAA5555, 2'b11, 5'd3, 5'd3);
        checkOutput("byp_p0", dataM[31:0], 32'hAAAA5555);
        checkOutput("byp_p1", dataM[63:32], 32'hAAAA5555);
        checkOutput("nobyp_p0", dataN[31:0], 32'h1);
        checkOutput("nobyp_p1", dataN[63:32], 32'h1);

        // Register 0 stays zero even with a same-cycle write.
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 2'b11, 5'd0, 5'd0);
        checkOutput("r0_byp", dataM[31:0], 32'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd3);
        checkOutput("r0_stored", dataM[31:0], 32'h0);
        checkOutput("r3_stored", dataM[63:32], 32'hAAAA5555);

        // Out-of-range access on the DEPTH=20 instance.
        applyStimulus(1'b1, 5'd25, 32'h5, 2'b11, 5'd25, 5'd25);
        checkOutput("r25_byp", dataS[31:0], 32'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 2'b11, 5'd25, 5'd5);
        checkOutput("r25_read", dataS[31:0], 32'h0);
        checkOutput("r25_alias_r5", dataS[63:32], 32'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd7);
        checkOutput("r25_alias_r9", dataS[31:0], 32'h0);
        checkOutput("small_r7", dataS[63:32], 32'h12345678);

        // Fill r1..r31 with their index, then run a full clear.
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b1, i[4:0], 32'(i), 2'b00, 5'd0, 5'd0);
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 2'b11, 5'd20, 5'd31);
        checkOutput("fill_r20", dataM[31:0], 32'd20);
        checkOutput("fill_r31", dataM[63:32], 32'd31);
        rd_en   = 2'b00;
        clr_req = 1'b1;
        checkOutput("busy_before_edge", 32'(busyM), 32'h0);
        stepClock();
        clr_req = 1'b0;
        checkOutput("busy_rise", 32'(busyM), 32'h1);
        checkOutput("done_early", 32'(doneM), 32'h0);
        cnt = 0;
        while (!doneM && cnt < 100) begin
            if (cnt == 15) begin
                we      = 1'b1;
                wr_addr = 5'd9;
                wr_data = 32'h77;
                rd_en   = 2'b11;
                rd_addr = {5'd9, 5'd20};
            end
            stepClock();
            cnt++;
            if (cnt == 16) begin
                checkOutput("mid_r20_old", dataM[31:0], 32'd20);
                checkOutput("mid_r9_nobyp", dataM[63:32], 32'h0);
                checkOutput("mid_busy", 32'(busyM), 32'h1);
                we    = 1'b0;
                rd_en = 2'b00;
            end
        end
        checkOutput("clr_latency", 32'(cnt), 32'd32);
        checkOutput("done_busy", 32'(busyM), 32'h1);
        stepClock();
        checkOutput("done_pulse_end", 32'(doneM), 32'h0);
        checkOutput("busy_end", 32'(busyM), 32'h0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 2'b11, i[4:0], 5'(i + 16));
            checkOutput($sformatf("clr_r%0d", i), dataM[31:0], 32'h0);
            checkOutput($sformatf("clr_r%0d", i + 16), dataM[63:32], 32'h0);
        end

        // Reset in the middle of a clear sweep.
        applyStimulus(1'b1, 5'd30, 32'h30, 2'b00, 5'd0, 5'd0);
        applyStimulus(1'b1, 5'd4, 32'h44, 2'b00, 5'd0, 5'd0);
        we      = 1'b0;
        clr_req = 1'b1;
        stepClock();
        clr_req = 1'b0;
        repeat (10) stepClock();
        checkOutput("rstmid_busy_before", 32'(busyM), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_busy", 32'(busyM), 32'h0);
        checkOutput("rstmid_done", 32'(doneM), 32'h0);
        rst_n   = 1'b1;
        sawDone = 1'b0;
        repeat (40) begin
            stepClock();
            if (doneM) sawDone = 1'b1;
        end
        checkOutput("rstmid_no_done", 32'(sawDone), 32'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 2'b11, 5'd30, 5'd4);
        checkOutput("rstmid_r30", dataM[31:0], 32'h0);
        checkOutput("rstmid_r4", dataM[63:32], 32'h0);
        rd_en   = 2'b00;
        clr_req = 1'b1;
        stepClock();
        clr_req = 1'b0;
        cnt = 0;
        while (!doneM && cnt < 100) begin
            stepClock();
            cnt++;
        end
        checkOutput("clr2_latency", 32'(cnt), 32'd32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
